prog_mod_counter: RTL and testbench

Parametrised, runtime-programmable modulo counter, the general counting primitive for the attitude-indicator pixel, line and frame timing chains. It adds count enable, up/down direction, synchronous clear and load, a runtime-writable terminal value, and a wrap or saturate mode. It also produces registered wrap/limit pulses and terminal flags, so several instances can be cascaded.

---
 rtl/prog_mod_counter.sv | 116 +++++++++++
 tb/tb_prog_mod_counter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mod_counter.sv
// prog_mod_counter
//
// Runtime-programmable modulo counter used as the building block of the
// attitude-indicator pixel, line and frame timing chains. The terminal value
// can be rewritten while running. In wrap mode the counter rolls over; in
// saturate mode it holds at the bound. A registered wrap/limit pulse and
// decoded terminal flags allow several instances to be cascaded.
//
// Parameters
//   WIDTH        counter and terminal-value width in bits (>= 1)
//   DEFAULT_MAX  terminal value loaded at reset
//   SATURATE     0 = wrap at the bound, 1 = hold at the bound
//
// Ports
//   reset         in   asynchronous, active-high reset
//   clock         in   rising-edge clock
//   i_Enable      in   advance one step per cycle while high
//   i_Up          in   1 = increment, 0 = decrement
//   i_Clear       in   synchronous clear to 0 (highest priority)
//   i_Load        in   synchronous load of i_Load_Value, clamped to max
//   i_Load_Value  in   value for load
//   i_Max_Write   in   latch i_Max_Value as the new terminal value
//   i_Max_Value   in   new terminal value
//   o_Counter     out  current count (registered)
//   o_Max         out  current terminal value (registered)
//   o_Wrap        out  one-cycle wrap / limit-hit pulse (registered)
//   o_At_Max      out  o_Counter == o_Max
//   o_At_Zero     out  o_Counter == 0

module prog_mod_counter #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] DEFAULT_MAX = 8'd255,
    parameter bit               SATURATE    = 1'b0
) (
    input  logic             reset,
    input  logic             clock,
    input  logic             i_Enable,
    input  logic             i_Up,
    input  logic             i_Clear,
    input  logic             i_Load,
    input  logic [WIDTH-1:0] i_Load_Value,
    input  logic             i_Max_Write,
    input  logic [WIDTH-1:0] i_Max_Value,
    output logic [WIDTH-1:0] o_Counter,
    output logic [WIDTH-1:0] o_Max,
    output logic             o_Wrap,
    output logic             o_At_Max,
    output logic             o_At_Zero
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] max_value;
    logic             wrap;

    logic [WIDTH-1:0] count_next;
    logic             wrap_next;
    logic [WIDTH-1:0] load_limit;

    // A load in the same cycle as a max write is clamped against the value
    // being written, so the counter never lands above the new terminal value.
    assign load_limit = i_Max_Write ? i_Max_Value : max_value;

    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;

        if (i_Clear) begin
            count_next = '0;
        end else if (i_Load) begin
            count_next = (i_Load_Value > load_limit) ? load_limit : i_Load_Value;
        end else if (i_Max_Write && (count > i_Max_Value)) begin
            // New terminal value is below the current count: restart from 0
            // and skip counting this cycle.
            count_next = '0;
        end else if (i_Enable) begin
            // Counting uses the terminal value currently in effect; a max
            // write in this cycle only takes effect from the next cycle.
            if (i_Up) begin
                if (count == max_value) begin
                    wrap_next  = 1'b1;
                    count_next = SATURATE ? count : '0;
                end else begin
                    count_next = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    wrap_next  = 1'b1;
                    count_next = SATURATE ? count : max_value;
                end else begin
                    count_next = count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            max_value <= DEFAULT_MAX;
            wrap      <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= wrap_next;
            if (i_Max_Write) begin
                max_value <= i_Max_Value;
            end
        end
    end

    assign o_Counter = count;
    assign o_Max     = max_value;
    assign o_Wrap    = wrap;
    assign o_At_Max  = (count == max_value);
    assign o_At_Zero = (count == '0);

endmodule

// File: tb/tb_prog_mod_counter.sv
// Testbench for prog_mod_counter: a wrap-mode and a saturate-mode instance
// (WIDTH=4, DEFAULT_MAX=9) are driven with identical stimulus. Expected
// results are pushed to a queue per instance as stimulus is applied and
// popped after the clock edge, plus directed checks of the key sequences.

module tb_prog_mod_counter;

    localparam int             W    = 4;
    localparam logic [W-1:0]   DMAX = 4'd9;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable, up, clear, load, max_write;
    logic [W-1:0] load_value, max_value;

    logic [W-1:0] w_counter, w_max, s_counter, s_max;
    logic         w_wrap, w_at_max, w_at_zero;
    logic         s_wrap, s_at_max, s_at_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic [W-1:0] mx;
        logic         wrap;
    } exp_t;

    exp_t q_w[$];
    exp_t q_s[$];
    exp_t mw;
    exp_t ms;

    always #5 clock = ~clock;

    prog_mod_counter #(.WIDTH(W), .DEFAULT_MAX(DMAX), .SATURATE(1'b0)) dut_w (
        .reset(reset), .clock(clock),
        .i_Enable(enable), .i_Up(up), .i_Clear(clear),
        .i_Load(load), .i_Load_Value(load_value),
        .i_Max_Write(max_write), .i_Max_Value(max_value),
        .o_Counter(w_counter), .o_Max(w_max), .o_Wrap(w_wrap),
        .o_At_Max(w_at_max), .o_At_Zero(w_at_zero)
    );

    prog_mod_counter #(.WIDTH(W), .DEFAULT_MAX(DMAX), .SATURATE(1'b1)) dut_s (
        .reset(reset), .clock(clock),
        .i_Enable(enable), .i_Up(up), .i_Clear(clear),
        .i_Load(load), .i_Load_Value(load_value),
        .i_Max_Write(max_write), .i_Max_Value(max_value),
        .o_Counter(s_counter), .o_Max(s_max), .o_Wrap(s_wrap),
        .o_At_Max(s_at_max), .o_At_Zero(s_at_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference behaviour for one clock edge given the currently driven inputs.
    function automatic exp_t model_next(input bit sat, input exp_t cur);
        exp_t nx;
        int   c, m, lim;
        c   = int'(cur.cnt);
        m   = int'(cur.mx);
        lim = max_write ? int'(max_value) : m;
        nx.wrap = 1'b0;
        if (clear) c = 0;
        else if (load) c = (int'(load_value) < lim) ? int'(load_value) : lim;
        else if (max_write && c > int'(max_value)) c = 0;
        else if (enable) begin
            if (up) begin
                if (c == m) begin nx.wrap = 1'b1; if (!sat) c = 0; end
                else c = c + 1;
            end else begin
                if (c == 0) begin nx.wrap = 1'b1; if (!sat) c = m; end
                else c = c - 1;
            end
        end
        if (max_write) m = int'(max_value);
        nx.cnt = W'(c);
        nx.mx  = W'(m);
        return nx;
    endfunction

    task automatic drive(input logic en, input logic u, input logic clr, input logic ld,
                         input logic [W-1:0] lv, input logic mwr, input logic [W-1:0] mv);
        enable = en; up = u; clear = clr; load = ld;
        load_value = lv; max_write = mwr; max_value = mv;
    endtask

    task automatic step();
        exp_t e;
        mw = model_next(1'b0, mw);
        q_w.push_back(mw);
        ms = model_next(1'b1, ms);
        q_s.push_back(ms);
        @(posedge clock);
        #1;
        e = q_w.pop_front();
        check("w_counter", w_counter, e.cnt);
        check("w_max", w_max, e.mx);
        check("w_wrap", w_wrap, e.wrap);
        check("w_at_max", w_at_max, e.cnt == e.mx);
        check("w_at_zero", w_at_zero, e.cnt == '0);
        e = q_s.pop_front();
        check("s_counter", s_counter, e.cnt);
        check("s_max", s_max, e.mx);
        check("s_wrap", s_wrap, e.wrap);
        check("s_at_max", s_at_max, e.cnt == e.mx);
        check("s_at_zero", s_at_zero, e.cnt == '0);
        @(negedge clock);
    endtask

    initial begin
        int nw;
        reset = 1'b1;
        drive(0, 1, 0, 0, '0, 0, '0);
        mw = '{cnt: '0, mx: DMAX, wrap: 1'b0};
        ms = mw;

        @(negedge clock);
        check("rst_counter", w_counter, 0);
        check("rst_max", w_max, 9);
        check("rst_wrap", w_wrap, 0);
        check("rst_at_zero", w_at_zero, 1);
        check("rst_at_max", w_at_max, 0);
        check("rst_s_max", s_max, 9);
        reset = 1'b0;

        // Wrap mode up-count: two full periods of 10
        drive(1, 1, 0, 0, '0, 0, '0);
        nw = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("up_seq", w_counter, k % 10);
            check("up_wrap", w_wrap, (k % 10) == 0);
            if (w_wrap) nw++;
        end
        check("up_wraps", nw, 2);

        // Down-count from 0 with max 9
        drive(0, 1, 1, 0, '0, 0, '0);
        step();
        drive(1, 0, 0, 0, '0, 0, '0);
        for (int k = 1; k <= 11; k++) begin
            step();
            check("down_seq", w_counter, (20 - k) % 10);
            check("down_wrap", w_wrap, (k == 1) || (k == 11));
        end

        // Saturate mode: max 5, up 8 then down 7
        drive(0, 1, 1, 0, '0, 1, 4'd5);
        step();
        drive(1, 1, 0, 0, '0, 0, '0);
        nw = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("sat_up", s_counter, (k < 5) ? k : 5);
            if (s_wrap) nw++;
        end
        check("sat_wraps", nw, 3);
        drive(1, 0, 0, 0, '0, 0, '0);
        for (int k = 1; k <= 7; k++) begin
            step();
            check("sat_down", s_counter, (k < 5) ? (5 - k) : 0);
        end

        // Priority: clear over load over count; load clamps to max
        drive(0, 1, 0, 1, 4'd7, 1, 4'd9);
        step();
        check("prio_load7", w_counter, 7);
        drive(1, 1, 1, 1, 4'd3, 0, '0);
        step();
        check("prio_clear", w_counter, 0);
        drive(0, 1, 0, 1, 4'd12, 0, '0);
        step();
        check("prio_load_clamp", w_counter, 9);
        drive(0, 1, 0, 1, 4'd4, 1, 4'd2);
        step();
        check("prio_load_newmax", w_counter, 2);
        check("prio_newmax", w_max, 2);

        // Max write below current count
        drive(0, 1, 0, 1, 4'd8, 1, 4'd9);
        step();
        check("mw_pre", w_counter, 8);
        drive(1, 1, 0, 0, '0, 1, 4'd5);
        step();
        check("mw_counter", w_counter, 0);
        check("mw_max", w_max, 5);
        check("mw_wrap", w_wrap, 0);
        drive(1, 1, 0, 0, '0, 0, '0);
        nw = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("mw_seq", w_counter, k % 6);
            if (w_wrap) nw++;
        end
        check("mw_wraps", nw, 2);

        // Asynchronous reset mid-cycle with a programmed max
        drive(0, 1, 0, 1, 4'd6, 1, 4'd12);
        step();
        check("ar_pre", w_counter, 6);
        drive(1, 1, 0, 0, '0, 0, '0);
        #2;
        reset = 1'b1;
        #1;
        check("ar_counter", w_counter, 0);
        check("ar_max", w_max, 9);
        check("ar_wrap", w_wrap, 0);
        check("ar_at_zero", w_at_zero, 1);
        check("ar_s_max", s_max, 9);
        mw = '{cnt: '0, mx: DMAX, wrap: 1'b0};
        ms = mw;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("ar_resume", w_counter, k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
